seq_serializer: RTL

Parallel-to-serial front end for the bit-serial sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `sout`, which drives the detector's `in` input directly. Back-to-back words produce a gap-free bit stream, so patterns that straddle word boundaries are still detected. When no word is loaded, the line idles at a fixed level.

---
 rtl/seq_pkg.sv | 9 +
 rtl/seq_serializer_if.sv | 23 ++
 rtl/seq_serializer.sv | 107 ++++++++++
 3 files changed

// File: rtl/seq_pkg.sv
// Shared definitions for the serializer and the detector-side benches.
package seq_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // Default word width shared with the detector-side testbench.
  localparam int SEQ_WORD_W = 8;

endpackage

// File: rtl/seq_serializer_if.sv
// Word-in / bit-out bundle between a word producer and the serializer.
interface seq_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] din;
  logic             din_valid;
  logic             din_ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;

  // Producer side: drives words, observes the serial stream.
  modport master (
    output din, din_valid,
    input  din_ready, sout, sout_valid, word_done
  );

  // Serializer side.
  modport slave (
    input  din, din_valid,
    output din_ready, sout, sout_valid, word_done
  );
endinterface

// File: rtl/seq_serializer.sv
// Parallel-to-serial front end: accepts WIDTH-bit words and shifts them out
// one bit per clock, reloading on the last bit so back-to-back words form a
// gap-free stream.
module seq_serializer
  import seq_pkg::*;
#(
  parameter int   WIDTH     = SEQ_WORD_W,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input logic             clk,
  input logic             rst,
  seq_serializer_if.slave bus
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state;
  ser_state_t       state_next;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] shreg_shifted;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             serial_bit;
  logic             last_bit;
  logic             accept;

  logic             ready;
  logic             sout;
  logic             sout_valid;
  logic             word_done;

  // Shift direction is fixed at elaboration; the outgoing bit is always the
  // one that the next shift discards.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign shreg_shifted = {shreg[WIDTH-2:0], 1'b0};
      assign serial_bit    = shreg[WIDTH-1];
    end else begin : g_lsb_first
      assign shreg_shifted = {1'b0, shreg[WIDTH-1:1]};
      assign serial_bit    = shreg[0];
    end
  endgenerate

  assign last_bit = (cnt == '0);
  assign accept   = bus.din_valid && ready;

  // State, shift register and bit counter; reset wins over any accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      cnt   <= cnt_next;
    end
  end

  // Next state: load on accept, otherwise shift and count down to idle.
  always_comb begin
    state_next = state;
    shreg_next = shreg;
    cnt_next   = cnt;
    case (state)
      S_IDLE: begin
        if (accept) begin
          state_next = S_SHIFT;
          shreg_next = bus.din;
          cnt_next   = CNT_LAST;
        end
      end
      S_SHIFT: begin
        if (accept) begin
          // Only possible on the last bit: seamless reload, no idle gap.
          shreg_next = bus.din;
          cnt_next   = CNT_LAST;
        end else begin
          shreg_next = shreg_shifted;
          cnt_next   = cnt - CNT_W'(1);
          if (last_bit) begin
            state_next = S_IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Outputs come from registers only; ready is additionally held low in reset.
  always_comb begin
    sout_valid = (state == S_SHIFT);
    sout       = (state == S_SHIFT) ? serial_bit : IDLE_BIT;
    word_done  = (state == S_SHIFT) && last_bit;
    ready      = !rst && ((state == S_IDLE) || last_bit);
  end

  assign bus.din_ready  = ready;
  assign bus.sout       = sout;
  assign bus.sout_valid = sout_valid;
  assign bus.word_done  = word_done;

endmodule
